accum_bank: RTL

Parametrised per-column accumulator memory that receives systolic-array column outputs and holds partial sums across tiles. Each column is an independent bank with these features:
- two-stage read-modify-write pipeline with same-address forwarding
- wide accumulator words with a sign-extended input
- accumulate or overwrite write mode
- sequenced per-column clear sweep with busy status

It sits between the systolic array output and the output/activation unit.

---
 rtl/accum_bank_if.sv | 44 ++++
 rtl/accum_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_bank_if.sv
// Per-column clear/write/read bundle for accum_bank; master drives requests, slave is the bank.
// With ACCUM_SAT_EN defined the bundle also carries the sticky per-column sat_flag vector.
interface accum_bank_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int ACC_WIDTH      = 24,
   parameter int SYS_ARR_COLS   = 16,
   parameter int NUM_ACCUM_ROWS = 1024
);
   localparam int AW = (NUM_ACCUM_ROWS > 1) ? $clog2(NUM_ACCUM_ROWS) : 1;

   logic [SYS_ARR_COLS-1:0]            clear;
   logic [SYS_ARR_COLS-1:0]            busy;
   logic [SYS_ARR_COLS-1:0]            wr_en;
   logic [SYS_ARR_COLS-1:0]            wr_mode;
   logic [AW*SYS_ARR_COLS-1:0]         wr_addr;
   logic [DATA_WIDTH*SYS_ARR_COLS-1:0] wr_data;
   logic [SYS_ARR_COLS-1:0]            rd_en;
   logic [AW*SYS_ARR_COLS-1:0]         rd_addr;
   logic [ACC_WIDTH*SYS_ARR_COLS-1:0]  rd_data;
   logic [SYS_ARR_COLS-1:0]            rd_valid;
   logic [SYS_ARR_COLS-1:0]            wr_drop;

`ifdef ACCUM_SAT_EN
   logic [SYS_ARR_COLS-1:0]            sat_flag;

   modport master (
      output clear, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
      input  busy, rd_data, rd_valid, wr_drop, sat_flag
   );
   modport slave (
      input  clear, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
      output busy, rd_data, rd_valid, wr_drop, sat_flag
   );
`else
   modport master (
      output clear, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
      input  busy, rd_data, rd_valid, wr_drop
   );
   modport slave (
      input  clear, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
      output busy, rd_data, rd_valid, wr_drop
   );
`endif
endinterface

// File: rtl/accum_bank.sv
// Per-column accumulator banks: 2-stage read-modify-write with S2->S1 forwarding and a clear sweep.
// Optional ACCUM_SAT_EN: accumulate clamps to signed ACC_WIDTH limits and drives sticky sat_flag.
module accum_bank #(
   parameter int DATA_WIDTH     = 8,
   parameter int ACC_WIDTH      = 24,
   parameter int SYS_ARR_COLS   = 16,
   parameter int NUM_ACCUM_ROWS = 1024
) (
   input logic         clk,
   input logic         reset,
   accum_bank_if.slave bus
);
   localparam int AW = (NUM_ACCUM_ROWS > 1) ? $clog2(NUM_ACCUM_ROWS) : 1;
   localparam bit ROWS_POW2 = ((1 << AW) == NUM_ACCUM_ROWS);
   localparam logic [AW-1:0] LAST_ROW = AW'(NUM_ACCUM_ROWS - 1);
`ifdef ACCUM_SAT_EN
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

   typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} sweep_state_e;

   genvar c;
   for (c = 0; c < SYS_ARR_COLS; c++) begin : g_col
      logic [AW-1:0]                wr_addr_s;
      logic [AW-1:0]                rd_addr_s;
      logic signed [DATA_WIDTH-1:0] wr_data_s;
      logic [ACC_WIDTH-1:0]         wr_ext_s;
      logic                         wr_in_range_s;
      logic                         rd_in_range_s;
      logic                         sweeping_s;
      logic [ACC_WIDTH-1:0]         new_s;
      logic                         mem_we_s;
      logic [AW-1:0]                mem_waddr_s;
      logic [ACC_WIDTH-1:0]         mem_wdata_s;
      logic [ACC_WIDTH-1:0]         mem_q [NUM_ACCUM_ROWS];

      sweep_state_e                 state_q, state_d;
      logic [AW-1:0]                cnt_q, cnt_d;
      logic                         busy_q, busy_d;
      logic                         s2_valid_q, s2_valid_d;
      logic [AW-1:0]                s2_addr_q, s2_addr_d;
      logic [ACC_WIDTH-1:0]         s2_data_q, s2_data_d;
      logic                         s2_mode_q, s2_mode_d;
      logic [ACC_WIDTH-1:0]         s2_old_q, s2_old_d;
      logic                         rd_valid_q, rd_valid_d;
      logic [ACC_WIDTH-1:0]         rd_data_q, rd_data_d;
      logic                         wr_drop_q, wr_drop_d;

      assign wr_addr_s  = bus.wr_addr[c*AW +: AW];
      assign rd_addr_s  = bus.rd_addr[c*AW +: AW];
      assign wr_data_s  = bus.wr_data[c*DATA_WIDTH +: DATA_WIDTH];
      assign wr_ext_s   = ACC_WIDTH'(wr_data_s);
      assign sweeping_s = (state_q == SWEEP);

      // Rows past NUM_ACCUM_ROWS only exist when the depth is not a power of two.
      if (ROWS_POW2) begin : g_pow2
         assign wr_in_range_s = 1'b1;
         assign rd_in_range_s = 1'b1;
      end else begin : g_npow2
         assign wr_in_range_s = (wr_addr_s <= LAST_ROW);
         assign rd_in_range_s = (rd_addr_s <= LAST_ROW);
      end

`ifdef ACCUM_SAT_EN
      logic [ACC_WIDTH:0] sum_s;
      logic               sat_hit_s;
      logic               sat_flag_q, sat_flag_d;

      // S2 result with signed clamping on accumulate overflow.
      always_comb begin
         sum_s     = {s2_old_q[ACC_WIDTH-1], s2_old_q} + {s2_data_q[ACC_WIDTH-1], s2_data_q};
         sat_hit_s = 1'b0;
         if (s2_mode_q) begin
            new_s = s2_data_q;
         end else if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
            new_s     = sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            sat_hit_s = s2_valid_q & ~sweeping_s;
         end else begin
            new_s = sum_s[ACC_WIDTH-1:0];
         end
         if (bus.clear[c]) begin
            sat_flag_d = 1'b0;
         end else begin
            sat_flag_d = sat_flag_q | sat_hit_s;
         end
      end

      // Sticky clamp indicator.
      always_ff @(posedge clk) begin
         if (reset) begin
            sat_flag_q <= 1'b0;
         end else begin
            sat_flag_q <= sat_flag_d;
         end
      end

      assign bus.sat_flag[c] = sat_flag_q;
`else
      // S2 result, two's-complement wrap.
      always_comb begin
         if (s2_mode_q) begin
            new_s = s2_data_q;
         end else begin
            new_s = s2_old_q + s2_data_q;
         end
      end
`endif

      // Clear FSM next state, write stage S1, read port and memory write port.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            IDLE: begin
               if (bus.clear[c]) begin
                  state_d = SWEEP;
               end else begin
                  state_d = IDLE;
               end
            end
            SWEEP: begin
               if (cnt_q == LAST_ROW) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + AW'(1'b1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
         busy_d = (state_d == SWEEP);

         s2_valid_d = bus.wr_en[c] & ~sweeping_s & wr_in_range_s;
         s2_addr_d  = wr_addr_s;
         s2_data_d  = wr_ext_s;
         s2_mode_d  = bus.wr_mode[c];
         if (s2_valid_q && (s2_addr_q == wr_addr_s)) begin
            s2_old_d = new_s;
         end else begin
            s2_old_d = mem_q[wr_addr_s];
         end
         wr_drop_d = wr_drop_q | (bus.wr_en[c] & sweeping_s);

         rd_valid_d = bus.rd_en[c];
         if (!bus.rd_en[c]) begin
            rd_data_d = rd_data_q;
         end else if (sweeping_s || !rd_in_range_s) begin
            rd_data_d = '0;
         end else if (s2_valid_q && (s2_addr_q == rd_addr_s)) begin
            rd_data_d = new_s;
         end else begin
            rd_data_d = mem_q[rd_addr_s];
         end

         // An S2 write still in flight on the first sweep cycle is discarded: the sweep zeroes its row anyway.
         if (sweeping_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_q;
            mem_wdata_s = '0;
         end else begin
            mem_we_s    = s2_valid_q;
            mem_waddr_s = s2_addr_q;
            mem_wdata_s = new_s;
         end
      end

      // Control, pipeline and read-port registers.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            s2_mode_q  <= 1'b0;
            s2_old_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_drop_q  <= 1'b0;
         end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
            s2_mode_q  <= s2_mode_d;
            s2_old_q   <= s2_old_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            wr_drop_q  <= wr_drop_d;
         end
      end

      // Bank storage, single write port.
      always_ff @(posedge clk) begin
         if (mem_we_s && !reset) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
         end
      end

      assign bus.busy[c]                               = busy_q;
      assign bus.rd_valid[c]                           = rd_valid_q;
      assign bus.rd_data[c*ACC_WIDTH +: ACC_WIDTH]     = rd_data_q;
      assign bus.wr_drop[c]                            = wr_drop_q;
   end
endmodule
